// File: rtl/rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_pkg
// Shared types and helpers for the round-robin arbiter.
//   rr_state_e  : arbiter state {IDLE, BUSY}
//   rr_ptr_next : search start index following the last granted index
// ----------------------------------------------------------------------------
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rr_state_e;

    // Index after `last`, wrapping to 0 past the top requester.
    function automatic int unsigned rr_ptr_next(input int unsigned last,
                                                input int unsigned n);
        return (last + 1 >= n) ? 0 : last + 1;
    endfunction

endpackage : rr_arbiter_pkg

// File: rtl/rr_arbiter_lowest_set_enc.sv
// ----------------------------------------------------------------------------
// lowest_set_enc
// Lowest-index priority encoder.
//   bits  in  W           : candidate vector
//   idx   out $clog2(W)   : index of the lowest set bit (0 when none)
//   found out 1           : at least one bit of `bits` is set
// ----------------------------------------------------------------------------
module lowest_set_enc #(
    parameter int unsigned W = 8,
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  bits,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule : lowest_set_enc

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for N level-signalling requesters. Issues a registered
// one-hot grant and holds it until the holder drops its request; the next
// holder is picked on the same edge, searching upward from the index after
// the previous holder.
//
// Optional build macro: RR_ARBITER_TIMEOUT_EN
//   Adds a hold counter that forcibly revokes a grant after MAX_HOLD
//   consecutive cycles and pulses `timeout`. Without it `timeout` is tied 0.
//
// Ports:
//   clk          in   1    rising-edge clock
//   rst          in   1    synchronous active-high reset
//   req          in   N    request per requester, held for the transaction
//   grant        out  N    one-hot grant, registered
//   grant_id     out  IDW  binary index of the holder (valid with grant_valid)
//   grant_valid  out  1    grant is non-zero
//   timeout      out  1    one-cycle pulse on forced revocation
// ----------------------------------------------------------------------------
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout
);

    // Reject illegal configurations at elaboration.
    if (N < 2 || N > 64) begin : g_bad_n
        $error("rr_arbiter: N must be in 2..64");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("rr_arbiter: MAX_HOLD must be at least 1");
    end

    rr_state_e      state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           grant_valid_q, grant_valid_d;
    logic [IDW-1:0] last_id_q, last_id_d;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    logic           holder_req_c;
    logic           release_c;
    logic           revoke_c;
    logic           switch_c;
    logic [N-1:0]   elig_c;
    logic [N-1:0]   elig_masked_c;
    logic [IDW-1:0] ptr_c;
    logic [IDW-1:0] masked_idx_c, full_idx_c, pick_id_c;
    logic           masked_found_c, full_found_c, pick_found_c;
    logic [N-1:0]   pick_onehot_c;

    // Eligibility: the current holder is never eligible for its own
    // replacement; grant_q is zero in IDLE so this is plain req there.
    always_comb begin
        holder_req_c = |(req & grant_q);
        release_c    = (state_q == BUSY) && !holder_req_c;
        revoke_c     = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
        // A release in the same cycle wins: revoke needs the holder still requesting.
        revoke_c     = (state_q == BUSY) && holder_req_c &&
                       (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`endif
        switch_c     = release_c || revoke_c;
        elig_c       = req & ~grant_q;
    end

    // Search start and rotating mask: bits below ptr are dropped from the
    // masked search so indices at or above ptr win.
    always_comb begin
        ptr_c = IDW'(rr_ptr_next(32'(last_id_q), N));
        for (int unsigned i = 0; i < N; i++) begin
            elig_masked_c[i] = elig_c[i] && (i >= 32'(ptr_c));
        end
    end

    lowest_set_enc #(.W(N)) u_enc_masked (
        .bits  (elig_masked_c),
        .idx   (masked_idx_c),
        .found (masked_found_c)
    );

    lowest_set_enc #(.W(N)) u_enc_full (
        .bits  (elig_c),
        .idx   (full_idx_c),
        .found (full_found_c)
    );

    // Masked result wins; otherwise fall back to the lowest eligible index.
    always_comb begin
        pick_id_c    = masked_found_c ? masked_idx_c : full_idx_c;
        pick_found_c = full_found_c;
        for (int unsigned i = 0; i < N; i++) begin
            pick_onehot_c[i] = (pick_id_c == IDW'(i));
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (switch_c && !pick_found_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant datapath: load a new grant, clear it, or hold it.
    always_comb begin
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        last_id_d     = last_id_q;
`ifdef RR_ARBITER_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = revoke_c;
`endif
        if (((state_q == IDLE) || switch_c) && pick_found_c) begin
            grant_d       = pick_onehot_c;
            grant_id_d    = pick_id_c;
            grant_valid_d = 1'b1;
            last_id_d     = pick_id_c;
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt_d    = '0;
`endif
        end else if (switch_c) begin
            grant_d       = '0;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt_d    = '0;
`endif
        end else if (state_q == BUSY) begin
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt_d    = hold_cnt_q + CNT_W'(1);
`endif
        end
    end

    // State and output registers; last_id resets to N-1 so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            last_id_q     <= IDW'(N - 1);
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt_q    <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            last_id_q     <= last_id_d;
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
`ifdef RR_ARBITER_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter
// Directed bench for rr_arbiter with N=4, MAX_HOLD=4. Expected outputs are
// hand-computed; the timeout scenario expects different results depending on
// whether RR_ARBITER_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned IDW      = $clog2(N);

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N-1:0]   exp_grant;
        logic [IDW-1:0] exp_id;
        logic           exp_valid;
        logic           exp_timeout;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           timeout;

    int checks;
    int errors;
    vec_t vecs[$];

    rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g,
                       input logic [IDW-1:0] id, input logic v, input logic to);
        vec_t x;
        x.rst = r; x.req = rq; x.exp_grant = g; x.exp_id = id;
        x.exp_valid = v; x.exp_timeout = to;
        vecs.push_back(x);
    endtask

    // Drive inputs for one cycle and move to just after the sampling edge.
    task automatic step(input logic r, input logic [N-1:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [N-1:0] g,
                              input logic [IDW-1:0] id, input logic v, input logic to);
        checks++;
        if (grant !== g) begin
            errors++;
            $display("FAIL %s grant: got %b expected %b", name, grant, g);
        end
        checks++;
        if (grant_valid !== v) begin
            errors++;
            $display("FAIL %s grant_valid: got %b expected %b", name, grant_valid, v);
        end
        checks++;
        if (timeout !== to) begin
            errors++;
            $display("FAIL %s timeout: got %b expected %b", name, timeout, to);
        end
        if (v) begin
            checks++;
            if (grant_id !== id) begin
                errors++;
                $display("FAIL %s grant_id: got %0d expected %0d", name, grant_id, id);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = '0;

        //   rst  req      grant    id  v  to
        add(1, 4'b0000, 4'b0000, 0, 0, 0);   // reset state
        add(1, 4'b0101, 4'b0000, 0, 0, 0);   // reset overrides requests
        add(0, 4'b0101, 4'b0001, 0, 1, 0);   // first grant goes to 0
        add(0, 4'b0100, 4'b0100, 2, 1, 0);   // release -> next grant, no gap
        add(0, 4'b0100, 4'b0100, 2, 1, 0);   // hold
        add(0, 4'b0000, 4'b0000, 0, 0, 0);   // release, nobody waiting
        add(0, 4'b1000, 4'b1000, 3, 1, 0);   // last_id becomes 3
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 4'b0001, 0, 1, 0);   // rotation 0,1,2,3,0
        add(0, 4'b1110, 4'b0010, 1, 1, 0);
        add(0, 4'b1101, 4'b0100, 2, 1, 0);
        add(0, 4'b1011, 4'b1000, 3, 1, 0);
        add(0, 4'b0111, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 4'b0001, 0, 1, 0);   // holder keeps grant, others ignored
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1000, 4'b1000, 3, 1, 0);
        add(0, 4'b1001, 4'b1000, 3, 1, 0);   // holder 3 still requesting
        add(0, 4'b0000, 4'b0000, 0, 0, 0);   // idle with last_id=3
        add(0, 4'b1001, 4'b0001, 0, 1, 0);   // wrap to 0
        add(0, 4'b0100, 4'b0100, 2, 1, 0);
        add(0, 4'b0011, 4'b0001, 0, 1, 0);   // ptr=3 empty above -> lowest index
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0100, 2, 1, 0);
        add(1, 4'b0100, 4'b0000, 0, 0, 0);   // reset aborts grant
        add(0, 4'b1111, 4'b0001, 0, 1, 0);   // search restarts at 0
        add(0, 4'b0000, 4'b0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_id,
                       vecs[i].exp_valid, vecs[i].exp_timeout);
        end

        // Long hold by requester 1 while requester 3 waits.
        step(0, 4'b0010);
        expect_out("t5_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 4'b1010);
            expect_out($sformatf("t5_hold%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(0, 4'b1010);
`ifdef RR_ARBITER_TIMEOUT_EN
        expect_out("t5_revoke", 4'b1000, 2'd3, 1'b1, 1'b1);
`else
        expect_out("t5_revoke", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
        step(0, 4'b1010);
`ifdef RR_ARBITER_TIMEOUT_EN
        expect_out("t5_after", 4'b1000, 2'd3, 1'b1, 1'b0);
`else
        expect_out("t5_after", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
        step(0, 4'b0010);
        expect_out("t5_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(0, 4'b0000);
        expect_out("t5_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Holder releases in the very cycle a revoke would fire: plain release.
        step(0, 4'b0100);
        expect_out("rel_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 4'b0110);
            expect_out($sformatf("rel_hold%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step(0, 4'b0010);
        expect_out("rel_switch", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(0, 4'b0000);
        expect_out("rel_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter
